ndma_xfer_ctrl: RTL and testbench
=================================

# ndma_xfer_ctrl

Transfer sequencer for the NanoDMA engine. It takes a programmed transfer (source address, destination address, word count, start pulse) from the DMA register block and moves the words one at a time. Each word is read through an OBI read-manager port and written back through an OBI write-manager port. The block reports busy/done status and optionally raises a completion interrupt.

## Interface
- No parameters; data and address widths are fixed at 32 bits, and the length field is fixed at 8 bits.
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  single-cycle transfer request; sampled only in IDLE
- len_i  in  8  number of 32-bit words to move; sampled with start_i
- src_addr_i  in  32  first read address; sampled with start_i
- dst_addr_i  in  32  first write address; sampled with start_i
- busy_o  out  1  high from the cycle after start acceptance until return to IDLE
- done_o  out  1  one-cycle pulse on transfer completion
- rd_req_o / rd_gnt_i / rd_addr_o  out/in/out  1/1/32  OBI read request phase
- rd_rvalid_i / rd_rdata_i  in  1/32  OBI read response phase
- wr_req_o / wr_gnt_i / wr_addr_o / wr_wdata_o / wr_be_o  out/in/out/out/out  1/1/32/32/4  OBI write request phase; wr_be_o is always 4'hF
- wr_rvalid_i  in  1  OBI write response
- irq_o  out  1  completion interrupt (level)
- irq_clr_i  in  1  clears irq_o

## Operation
- The controller is a single FSM with six states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- **IDLE:**
  - If start_i is high, latch src, dst and len into internal counters.
  - If len_i==0, go to DONE; no bus traffic occurs.
  - Otherwise go to RD_REQ.
- **RD_REQ:** rd_req_o=1 and rd_addr_o=current src. Hold both until rd_gnt_i, then go to RD_WAIT.
- **RD_WAIT:** on rd_rvalid_i, capture rd_rdata_i into a 32-bit data buffer and go to WR_REQ.
- **WR_REQ:** wr_req_o=1, wr_addr_o=current dst, wr_wdata_o=buffer. Hold all of them stable until wr_gnt_i, then go to WR_WAIT.
- **WR_WAIT:** on wr_rvalid_i:
  - src += 4 and dst += 4; both wrap modulo 2^32 and no overflow is flagged.
  - remaining -= 1.
  - If remaining becomes 0, go to DONE; otherwise go to RD_REQ.
- **DONE:** assert done_o for one cycle, set the interrupt flag, go to IDLE.
- A start_i outside IDLE is ignored; it is not queued.
- At most one outstanding transaction per port, and reads and writes never overlap.
- rd_rvalid_i in any state other than RD_WAIT, or wr_rvalid_i in any state other than WR_WAIT, is ignored.
- req is never dropped before gnt, and address/data must not change while req is high without gnt.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counters and buffer 0.
- Reset mid-transfer aborts immediately. The next transfer requires a fresh start_i.
- Latency:
  - start_i at cycle N gives rd_req_o high at N+1. With len==0, done_o is high at N+1.
  - With zero-wait-state subordinates (gnt in the same cycle as req, rvalid one cycle after gnt), each word takes 4 cycles.
  - A transfer of L words therefore raises done_o at N+1+4L.
- busy_o = (state != IDLE); it is also high during DONE.
- If start_i and irq_clr_i arrive in the same cycle, both take effect.
- If the interrupt flag set (DONE) and irq_clr_i coincide, the set wins.

## Configuration
- Controlled by the macro NDMA_IRQ_EN.
- **Defined:** irq_o is a level flag set in DONE and cleared by irq_clr_i (set has priority).
- **Undefined:** irq_o is tied to 0, irq_clr_i is unused, and the flag register is not instantiated. Ports are present in both builds.

## Structure
- Package ndma_pkg holds:
  - the FSM state enum typedef (xfer_state_e)
  - WordBytes=4
  - LenWidth=8
  - the full byte-enable constant 4'hF
- No sub-module. The FSM, the address/length counters and the data buffer sit in one module. The register block instantiates this controller and drives start_i from its config-write request bit.

## Test plan
- **Zero length:** len=0, start.
  - Expect done_o at N+1.
  - Expect no rd_req_o/wr_req_o.
  - Expect irq_o=1 when NDMA_IRQ_EN is defined.
- **Three-word copy:** len=3, src=0x1000, dst=0x2000, zero-wait memory holding 0xA,0xB,0xC.
  - Expect writes to 0x2000/0x2004/0x2008 with those data values.
  - Expect done_o at N+13.
- **Wait states:** gnt delayed 3 cycles and rvalid delayed 2 cycles.
  - Expect req, addr and wdata stable while waiting.
  - Expect correct data written.
  - Expect busy_o high throughout.
- **Address wrap:** src=0xFFFFFFFC, len=2.
  - Expect reads at 0xFFFFFFFC then 0x00000000.
- **Start while busy:** second start_i issued mid-transfer.
  - Expect it to be ignored, with exactly len writes performed.
  - Expect a start_i issued after done_o to launch a new transfer.
- **Reset mid-transfer:** rst_ni asserted during WR_REQ.
  - Expect all outputs 0 immediately.
  - Expect no further bus requests until the next start_i.

Source files
------------

// File: rtl/ndma_pkg.sv
// NanoDMA shared types and constants.
// Used by the transfer controller.
package ndma_pkg;

    localparam int         WordBytes = 4;
    localparam int         LenWidth  = 8;
    localparam logic [3:0] BeFull    = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        DONE
    } xfer_state_e;

endpackage

// File: rtl/ndma_xfer_ctrl.sv
// NanoDMA word-by-word transfer sequencer over OBI read/write ports.
// Define NDMA_IRQ_EN to build the completion interrupt flag.
module ndma_xfer_ctrl
    import ndma_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [LenWidth-1:0] len_i,
    input  logic [31:0]         src_addr_i,
    input  logic [31:0]         dst_addr_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                rd_req_o,
    input  logic                rd_gnt_i,
    output logic [31:0]         rd_addr_o,
    input  logic                rd_rvalid_i,
    input  logic [31:0]         rd_rdata_i,
    output logic                wr_req_o,
    input  logic                wr_gnt_i,
    output logic [31:0]         wr_addr_o,
    output logic [31:0]         wr_wdata_o,
    output logic [3:0]          wr_be_o,
    input  logic                wr_rvalid_i,
    output logic                irq_o,
    input  logic                irq_clr_i
);

    xfer_state_e         r_state;
    logic [31:0]         r_src;
    logic [31:0]         r_dst;
    logic [LenWidth-1:0] r_rem;
    logic [31:0]         r_buf;
    logic                r_rd_req;
    logic                r_wr_req;
    logic                r_done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_src    <= '0;
            r_dst    <= '0;
            r_rem    <= '0;
            r_buf    <= '0;
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_src <= src_addr_i;
                        r_dst <= dst_addr_i;
                        r_rem <= len_i;
                        if (len_i == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= RD_REQ;
                            r_rd_req <= 1'b1;
                        end
                    end
                end
                RD_REQ: begin
                    if (rd_gnt_i) begin
                        r_state  <= RD_WAIT;
                        r_rd_req <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (rd_rvalid_i) begin
                        r_buf    <= rd_rdata_i;
                        r_state  <= WR_REQ;
                        r_wr_req <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (wr_gnt_i) begin
                        r_state  <= WR_WAIT;
                        r_wr_req <= 1'b0;
                    end
                end
                WR_WAIT: begin
                    if (wr_rvalid_i) begin
                        // Addresses wrap silently at 2^32.
                        r_src <= r_src + 32'(WordBytes);
                        r_dst <= r_dst + 32'(WordBytes);
                        r_rem <= r_rem - 1'b1;
                        if (r_rem == LenWidth'(1)) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= RD_REQ;
                            r_rd_req <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    r_rd_req <= 1'b0;
                    r_wr_req <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = (r_state != IDLE);
    assign done_o     = r_done;
    assign rd_req_o   = r_rd_req;
    assign rd_addr_o  = r_src;
    assign wr_req_o   = r_wr_req;
    assign wr_addr_o  = r_dst;
    assign wr_wdata_o = r_buf;
    assign wr_be_o    = BeFull;

`ifdef NDMA_IRQ_EN
    logic r_irq;

    // Set in DONE beats a coincident clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq <= 1'b0;
        end else if (r_state == DONE) begin
            r_irq <= 1'b1;
        end else if (irq_clr_i) begin
            r_irq <= 1'b0;
        end
    end

    assign irq_o = r_irq;
`else
    logic w_unused_irq_clr;

    assign w_unused_irq_clr = irq_clr_i;
    assign irq_o            = 1'b0;
`endif

endmodule

// File: tb/tb_ndma_xfer_ctrl.sv
// Scoreboard bench for ndma_xfer_ctrl with a delay-configurable OBI memory.
// Define NDMA_IRQ_EN to also exercise the interrupt flag.
module tb_ndma_xfer_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [7:0]  len_i;
    logic [31:0] src_addr_i;
    logic [31:0] dst_addr_i;
    logic        busy_o;
    logic        done_o;
    logic        rd_req_o;
    logic        rd_gnt_i;
    logic [31:0] rd_addr_o;
    logic        rd_rvalid_i;
    logic [31:0] rd_rdata_i;
    logic        wr_req_o;
    logic        wr_gnt_i;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_wdata_o;
    logic [3:0]  wr_be_o;
    logic        wr_rvalid_i;
    logic        irq_o;
    logic        irq_clr_i;

    ndma_xfer_ctrl u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .len_i       (len_i),
        .src_addr_i  (src_addr_i),
        .dst_addr_i  (dst_addr_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rd_req_o    (rd_req_o),
        .rd_gnt_i    (rd_gnt_i),
        .rd_addr_o   (rd_addr_o),
        .rd_rvalid_i (rd_rvalid_i),
        .rd_rdata_i  (rd_rdata_i),
        .wr_req_o    (wr_req_o),
        .wr_gnt_i    (wr_gnt_i),
        .wr_addr_o   (wr_addr_o),
        .wr_wdata_o  (wr_wdata_o),
        .wr_be_o     (wr_be_o),
        .wr_rvalid_i (wr_rvalid_i),
        .irq_o       (irq_o),
        .irq_clr_i   (irq_clr_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_rd[$];
    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];

    int gnt_dly = 0;
    int rv_dly  = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hDEAD_0000 ^ a;
    endfunction

    // OBI memory model; also checks the request-phase rules.
    initial begin
        bit          rd_pend = 0, wr_pend = 0;
        int          rd_cnt = 0, wr_cnt = 0;
        int          rd_w = 0, wr_w = 0;
        logic [31:0] rd_a = '0, rd_h = '0, wa_h = '0, wd_h = '0;
        rd_gnt_i    = 0;
        rd_rvalid_i = 0;
        rd_rdata_i  = '0;
        wr_gnt_i    = 0;
        wr_rvalid_i = 0;
        forever begin
            @(negedge clk_i);
            rd_gnt_i    = 0;
            rd_rvalid_i = 0;
            wr_gnt_i    = 0;
            wr_rvalid_i = 0;
            if (!rst_ni) begin
                rd_pend = 0;
                wr_pend = 0;
                rd_w    = 0;
                wr_w    = 0;
            end else begin
                if (rd_req_o || wr_req_o) chk("busy_req", busy_o, 1);
                if (rd_req_o && wr_req_o) chk("rd_wr_overlap", 1, 0);
                if (rd_pend) begin
                    if (rd_cnt == rv_dly) begin
                        rd_rvalid_i = 1;
                        rd_rdata_i  = mem_rd(rd_a);
                        rd_pend     = 0;
                    end else rd_cnt++;
                end else if (rd_req_o) begin
                    if (rd_w == 0) rd_h = rd_addr_o;
                    else chk("rd_addr_hold", rd_addr_o, rd_h);
                    if (rd_w == gnt_dly) begin
                        rd_gnt_i = 1;
                        rd_pend  = 1;
                        rd_cnt   = 0;
                        rd_a     = rd_addr_o;
                        rd_w     = 0;
                        if (exp_rd.size() == 0) chk("rd_unexpected", rd_addr_o, 0);
                        else chk("rd_addr", rd_addr_o, exp_rd.pop_front());
                    end else rd_w++;
                end else if (rd_w != 0) begin
                    chk("rd_req_dropped", 0, 1);
                    rd_w = 0;
                end
                if (wr_pend) begin
                    if (wr_cnt == rv_dly) begin
                        wr_rvalid_i = 1;
                        wr_pend     = 0;
                    end else wr_cnt++;
                end else if (wr_req_o) begin
                    if (wr_w == 0) begin
                        wa_h = wr_addr_o;
                        wd_h = wr_wdata_o;
                    end else begin
                        chk("wr_addr_hold", wr_addr_o, wa_h);
                        chk("wr_data_hold", wr_wdata_o, wd_h);
                    end
                    if (wr_w == gnt_dly) begin
                        wr_gnt_i = 1;
                        wr_pend  = 1;
                        wr_cnt   = 0;
                        wr_w     = 0;
                        chk("wr_be", 32'(wr_be_o), 32'hF);
                        if (exp_wa.size() == 0) chk("wr_unexpected", wr_addr_o, 0);
                        else begin
                            chk("wr_addr", wr_addr_o, exp_wa.pop_front());
                            chk("wr_data", wr_wdata_o, exp_wd.pop_front());
                        end
                    end else wr_w++;
                end else if (wr_w != 0) begin
                    chk("wr_req_dropped", 0, 1);
                    wr_w = 0;
                end
            end
        end
    end

    task automatic launch(input int len, input logic [31:0] src,
                          input logic [31:0] dst, input logic [31:0] base,
                          input int gd, input int rd, output int c);
        logic [31:0] a;
        gnt_dly = gd;
        rv_dly  = rd;
        for (int i = 0; i < len; i++) begin
            a = src + 32'(4 * i);
            mem[a] = base + 32'(i);
            exp_rd.push_back(a);
            exp_wa.push_back(dst + 32'(4 * i));
            exp_wd.push_back(base + 32'(i));
        end
        @(negedge clk_i);
        start_i    = 1;
        len_i      = 8'(len);
        src_addr_i = src;
        dst_addr_i = dst;
        c          = cyc;
        @(negedge clk_i);
        start_i = 0;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        bit got = 0;
        for (int i = 0; i < 600; i++) begin
            if (done_o) begin
                got = 1;
                break;
            end
            @(negedge clk_i);
        end
        if (!got) chk({tag, "_timeout"}, 0, 1);
        else begin
            chk({tag, "_done_cyc"}, 32'(cyc), 32'(exp_cyc));
            chk({tag, "_busy_in_done"}, busy_o, 1);
        end
    endtask

    function automatic int word_cyc(input int gd, input int rd);
        return 2 * (gd + rd) + 4;
    endfunction

    initial begin
        int c;
        bit req_seen;
        rst_ni     = 0;
        start_i    = 0;
        len_i      = '0;
        src_addr_i = '0;
        dst_addr_i = '0;
        irq_clr_i  = 0;
        repeat (3) @(negedge clk_i);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rd_req", rd_req_o, 0);
        chk("rst_wr_req", wr_req_o, 0);
        chk("rst_rd_addr", rd_addr_o, 0);
        chk("rst_wr_addr", wr_addr_o, 0);
        chk("rst_wdata", wr_wdata_o, 0);
        chk("rst_irq", irq_o, 0);
        rst_ni = 1;
        repeat (2) @(negedge clk_i);

        // zero length: done at N+1, no traffic
        launch(0, 32'h100, 32'h200, 32'h0, 0, 0, c);
        chk("len0_no_rd", rd_req_o, 0);
        chk("len0_no_wr", wr_req_o, 0);
        wait_done("len0", c + 1);
        @(negedge clk_i);
        chk("len0_idle", busy_o, 0);
`ifdef NDMA_IRQ_EN
        chk("irq_set", irq_o, 1);
        irq_clr_i = 1;
        @(negedge clk_i);
        irq_clr_i = 0;
        chk("irq_clr", irq_o, 0);
`else
        chk("irq_tied", irq_o, 0);
`endif

        // three-word zero-wait copy
        launch(3, 32'h1000, 32'h2000, 32'hA, 0, 0, c);
        chk("copy_rd_req_n1", rd_req_o, 1);
        chk("copy_busy_n1", busy_o, 1);
        wait_done("copy3", c + 1 + 3 * word_cyc(0, 0));

        // wait states
        launch(2, 32'h1100, 32'h2100, 32'h5A00, 3, 2, c);
        wait_done("wait", c + 1 + 2 * word_cyc(3, 2));
`ifdef NDMA_IRQ_EN
        @(negedge clk_i);
        chk("irq_after_wait", irq_o, 1);
        irq_clr_i = 1;
        @(negedge clk_i);
        irq_clr_i = 0;
`endif

        // address wrap
        launch(2, 32'hFFFF_FFFC, 32'h6000, 32'h50, 0, 0, c);
        wait_done("wrap", c + 1 + 2 * word_cyc(0, 0));

        // start while busy is ignored
        launch(3, 32'h3000, 32'h4000, 32'h30, 1, 0, c);
        repeat (4) @(negedge clk_i);
        start_i    = 1;
        len_i      = 8'd5;
        src_addr_i = 32'h9000;
        dst_addr_i = 32'h9800;
        @(negedge clk_i);
        start_i = 0;
        wait_done("busy_start", c + 1 + 3 * word_cyc(1, 0));
        repeat (3) @(negedge clk_i);
        chk("busy_start_idle", busy_o, 0);
        launch(1, 32'h3400, 32'h4400, 32'h77, 0, 0, c);
        wait_done("after_done", c + 1 + word_cyc(0, 0));

        // reset during WR_REQ
        launch(4, 32'h7000, 32'h8000, 32'h70, 3, 0, c);
        req_seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (wr_req_o) begin
                req_seen = 1;
                break;
            end
            @(negedge clk_i);
        end
        chk("rst_mid_wr_req_seen", req_seen, 1);
        rst_ni = 0;
        #1;
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_done", done_o, 0);
        chk("rst_mid_rd_req", rd_req_o, 0);
        chk("rst_mid_wr_req", wr_req_o, 0);
        chk("rst_mid_rd_addr", rd_addr_o, 0);
        chk("rst_mid_wr_addr", wr_addr_o, 0);
        chk("rst_mid_wdata", wr_wdata_o, 0);
        chk("rst_mid_irq", irq_o, 0);
        exp_rd.delete();
        exp_wa.delete();
        exp_wd.delete();
        repeat (2) @(negedge clk_i);
        rst_ni   = 1;
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (rd_req_o || wr_req_o || busy_o) req_seen = 1;
        end
        chk("rst_mid_quiet", req_seen, 0);
        launch(2, 32'h7100, 32'h8100, 32'hC0, 0, 0, c);
        wait_done("post_rst", c + 1 + 2 * word_cyc(0, 0));

        repeat (3) @(negedge clk_i);
        chk("rd_q_empty", exp_rd.size(), 0);
        chk("wr_q_empty", exp_wa.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
